// File: rtl/dmem_wait_responder.sv
// -----------------------------------------------------------------------------
// dmem_wait_responder
//
// Word-addressed data memory for the pipelined MIPS core's data port. Each
// access takes a fixed number of cycles, and a one-cycle ready pulse marks its
// completion. This lets the core's memory-stall path be exercised.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two)
//   AW       index width, log2(DEPTH)
//   LATENCY  cycles from request acceptance to ready, 1..15
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   memwrite   store request, held by the core until ready
//   memread    load request, held by the core until ready
//   dataadr    byte address; word index is dataadr[AW+1:2]
//   writedata  store data, held until ready
//   readdata   registered load result; holds until the next load completes
//   ready      registered one-cycle completion pulse
//   err        misaligned-access flag, pulses together with ready
// -----------------------------------------------------------------------------
module dmem_wait_responder #(
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter runs from LATENCY-1 down to 0. With this range, ready rises
    // exactly LATENCY edges after the request is accepted.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // A sub-word byte offset marks the access as misaligned.
    function automatic logic is_misaligned(input logic [1:0] byte_ofs);
        return (byte_ofs != 2'b00);
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          mem_we_s;

    // Storage is intentionally left uninitialised on reset.
    logic [31:0]   mem_array [DEPTH];

    // Address bits above the index wrap the access modulo DEPTH.
    logic          unused_hi_s;
    assign unused_hi_s = ^dataadr[31:AW+2];

    // Next-state, capture and output logic for the IDLE/BUSY/DONE handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mis_d      = mis_q;
        readdata_d = readdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        mem_we_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (memwrite || memread) begin
                    // When both request lines are high, the access is a write.
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    wr_d    = memwrite;
                    idx_d   = dataadr[AW+1:2];
                    wdata_d = writedata;
                    mis_d   = is_misaligned(dataadr[1:0]);
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = mis_q;
                    // A misaligned read still returns the word at the truncated
                    // index. The load takes the value stored as of this edge.
                    if (!wr_q) begin
                        readdata_d = mem_array[idx_q];
                    end else begin
                        readdata_d = readdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                // The store commits only at the edge that ends the ready cycle.
                // A reset during the ready cycle forces IDLE first, so an
                // aborted store never reaches memory.
                state_d  = IDLE;
                mem_we_s = wr_q && !mis_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured-request and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            mis_q      <= 1'b0;
            readdata_q <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            mis_q      <= mis_d;
            readdata_q <= readdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Word storage write port. This array has no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    assign readdata = readdata_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule
